// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared types and constants for the memory-port arbiter.
//   t_arb_state   : arbiter FSM states
//   C_PRIO_RR     : pure round-robin arbitration
//   C_PRIO_CH0    : channel 0 wins whenever it requests
//   ack_latency() : cycles from grant decision to ack for a given memory latency
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_WAIT,
      S_ACK
   } t_arb_state;

   localparam int C_PRIO_RR  = 0;
   localparam int C_PRIO_CH0 = 1;

   function automatic int ack_latency(input int mem_latency);
      return mem_latency + 2;
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: requester side and memory side of the arbiter.
//   I_req/I_we/I_addr/I_wdata : flattened per-channel requests
//   O_ack/O_rdata             : per-channel completion pulse and read data
//   O_mem_*/I_mem_data        : single memory port (dpmem)
//   O_busy                    : transaction in flight
// Modport slave is the arbiter; master is the requesters plus the memory.
interface bus_arbiter_if #(
   parameter int P_channels  = 2,
   parameter int P_addr_bits = 16,
   parameter int P_data_bits = 8
);
   logic [P_channels-1:0]             I_req;
   logic [P_channels-1:0]             I_we;
   logic [P_channels*P_addr_bits-1:0] I_addr;
   logic [P_channels*P_data_bits-1:0] I_wdata;
   logic [P_channels-1:0]             O_ack;
   logic [P_channels*P_data_bits-1:0] O_rdata;
   logic [P_addr_bits-1:0]            O_mem_addr;
   logic                              O_mem_rden;
   logic                              O_mem_wren;
   logic [P_data_bits-1:0]            O_mem_data;
   logic [P_data_bits-1:0]            I_mem_data;
   logic                              O_busy;

   modport slave (
      input  I_req, I_we, I_addr, I_wdata, I_mem_data,
      output O_ack, O_rdata, O_mem_addr, O_mem_rden, O_mem_wren, O_mem_data, O_busy
   );

   modport master (
      output I_req, I_we, I_addr, I_wdata, I_mem_data,
      input  O_ack, O_rdata, O_mem_addr, O_mem_rden, O_mem_wren, O_mem_data, O_busy
   );
endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// bus_arbiter_rr_picker: combinational round-robin search.
//   req_i  : request vector
//   ptr_i  : last granted channel; search starts at ptr_i+1 and wraps
//   mask_i : channels excluded from the search
//   win_o  : first unmasked requester found
//   vld_o  : a winner exists
module bus_arbiter_rr_picker #(
   parameter int  P_channels = 2,
   localparam int C_IDX_W    = (P_channels > 1) ? $clog2(P_channels) : 1
) (
   input  logic [P_channels-1:0] req_i,
   input  logic [C_IDX_W-1:0]    ptr_i,
   input  logic [P_channels-1:0] mask_i,
   output logic [C_IDX_W-1:0]    win_o,
   output logic                  vld_o
);
   // One extra bit so ptr + offset (< 2*P_channels) never overflows before the wrap.
   logic [C_IDX_W:0] cand;

   always_comb begin
      win_o = '0;
      vld_o = 1'b0;
      cand  = '0;
      for (int i = 1; i <= P_channels; i++) begin
         cand = {1'b0, ptr_i} + (C_IDX_W + 1)'(i);
         if (cand >= (C_IDX_W + 1)'(P_channels)) begin
            cand = cand - (C_IDX_W + 1)'(P_channels);
         end
         if (!vld_o && req_i[cand[C_IDX_W-1:0]] && !mask_i[cand[C_IDX_W-1:0]]) begin
            vld_o = 1'b1;
            win_o = cand[C_IDX_W-1:0];
         end
      end
   end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: N-channel arbiter in front of one dpmem port.
//   I_clock : system clock
//   I_reset : asynchronous active-low reset
//   bus     : bus_arbiter_if.slave (requests, acks, read data, memory strobes)
// One transaction at a time: IDLE (grant) -> ACCESS (one-cycle strobe) ->
// WAIT (P_mem_latency cycles) -> ACK (one-cycle ack, read data valid).
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int P_channels    = 2,
   parameter int P_addr_bits   = 16,
   parameter int P_data_bits   = 8,
   parameter int P_mem_latency = 1,
   parameter int P_prio_mode   = C_PRIO_RR
) (
   input  logic         I_clock,
   input  logic         I_reset,
   bus_arbiter_if.slave bus
);
   localparam int C_IDX_W = (P_channels > 1) ? $clog2(P_channels) : 1;
   localparam int C_CNT_W = $clog2(ack_latency(P_mem_latency));
   // In priority mode channel 0 is decided outside the round-robin search.
   localparam logic [P_channels-1:0] C_RR_MASK =
      (P_prio_mode == C_PRIO_CH0) ? P_channels'(1) : '0;

   t_arb_state                        state_q, state_d;
   logic [C_IDX_W-1:0]                ptr_q, ptr_d;
   logic [C_IDX_W-1:0]                win_q, win_d;
   logic                              we_q, we_d;
   logic [P_addr_bits-1:0]            addr_q, addr_d;
   logic [P_data_bits-1:0]            wdata_q, wdata_d;
   logic                              rden_q, rden_d;
   logic                              wren_q, wren_d;
   logic [C_CNT_W-1:0]                cnt_q, cnt_d;
   logic [P_channels-1:0]             ack_q, ack_d;
   logic [P_channels*P_data_bits-1:0] rdata_q, rdata_d;
   logic                              busy_q, busy_d;

   logic [C_IDX_W-1:0]                pick_idx;
   logic                              pick_vld;
   logic [C_IDX_W-1:0]                grant_idx;
   logic                              grant_vld;

   bus_arbiter_rr_picker #(.P_channels(P_channels)) u_picker (
      .req_i  (bus.I_req),
      .ptr_i  (ptr_q),
      .mask_i (C_RR_MASK),
      .win_o  (pick_idx),
      .vld_o  (pick_vld)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      win_d     = win_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      busy_d    = busy_q;
      rden_d    = 1'b0;
      wren_d    = 1'b0;
      ack_d     = '0;
      grant_vld = 1'b0;
      grant_idx = '0;

      case (state_q)
         S_IDLE: begin
            // A channel-0 priority grant leaves the round-robin pointer alone.
            if (P_prio_mode == C_PRIO_CH0 && bus.I_req[0]) begin
               grant_vld = 1'b1;
            end else if (pick_vld) begin
               grant_vld = 1'b1;
               grant_idx = pick_idx;
               ptr_d     = pick_idx;
            end
            if (grant_vld) begin
               win_d   = grant_idx;
               we_d    = bus.I_we[grant_idx];
               addr_d  = bus.I_addr[grant_idx*P_addr_bits +: P_addr_bits];
               wdata_d = bus.I_wdata[grant_idx*P_data_bits +: P_data_bits];
               rden_d  = ~bus.I_we[grant_idx];
               wren_d  = bus.I_we[grant_idx];
               busy_d  = 1'b1;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            cnt_d   = C_CNT_W'(P_mem_latency - 1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Counter at zero means I_mem_data carries the strobed read this cycle.
            if (cnt_q == '0) begin
               ack_d[win_q] = 1'b1;
               busy_d       = 1'b0;
               state_d      = S_ACK;
               if (!we_q) begin
                  rdata_d[win_q*P_data_bits +: P_data_bits] = bus.I_mem_data;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         state_q <= S_IDLE;
         ptr_q   <= C_IDX_W'(P_channels - 1);
         win_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rden_q  <= 1'b0;
         wren_q  <= 1'b0;
         cnt_q   <= '0;
         ack_q   <= '0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rden_q  <= rden_d;
         wren_q  <= wren_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.O_ack      = ack_q;
   assign bus.O_rdata    = rdata_q;
   assign bus.O_mem_addr = addr_q;
   assign bus.O_mem_rden = rden_q;
   assign bus.O_mem_wren = wren_q;
   assign bus.O_mem_data = wdata_q;
   assign bus.O_busy     = busy_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed bench for bus_arbiter in four configurations:
//   dut_a : 2 channels, round-robin, latency 1 (read/write table)
//   dut_b : 4 channels, round-robin, latency 1 (fairness)
//   dut_c : 3 channels, channel-0 priority, latency 1
//   dut_d : 2 channels, round-robin, latency 3 (timing, async reset)
module tb_bus_arbiter;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   bus_arbiter_if #(.P_channels(2), .P_addr_bits(16), .P_data_bits(8)) ifa ();
   bus_arbiter_if #(.P_channels(4), .P_addr_bits(16), .P_data_bits(8)) ifb ();
   bus_arbiter_if #(.P_channels(3), .P_addr_bits(16), .P_data_bits(8)) ifc ();
   bus_arbiter_if #(.P_channels(2), .P_addr_bits(16), .P_data_bits(8)) ifd ();

   bus_arbiter #(.P_channels(2), .P_addr_bits(16), .P_data_bits(8), .P_mem_latency(1), .P_prio_mode(0))
      dut_a (.I_clock(clk), .I_reset(rst_n), .bus(ifa));
   bus_arbiter #(.P_channels(4), .P_addr_bits(16), .P_data_bits(8), .P_mem_latency(1), .P_prio_mode(0))
      dut_b (.I_clock(clk), .I_reset(rst_n), .bus(ifb));
   bus_arbiter #(.P_channels(3), .P_addr_bits(16), .P_data_bits(8), .P_mem_latency(1), .P_prio_mode(1))
      dut_c (.I_clock(clk), .I_reset(rst_n), .bus(ifc));
   bus_arbiter #(.P_channels(2), .P_addr_bits(16), .P_data_bits(8), .P_mem_latency(3), .P_prio_mode(0))
      dut_d (.I_clock(clk), .I_reset(rst_n), .bus(ifd));

   // Memory models. Data bus reads 0xEE when no read was strobed, so a
   // capture on the wrong cycle shows up as a data error.
   logic [7:0]  mem_a [0:65535];
   logic [7:0]  mem_d [0:65535];
   logic [7:0]  d_p1, d_p2;
   logic        pre_we = 1'b0;
   logic [15:0] pre_addr = '0;
   logic [7:0]  pre_dat = '0;

   always @(posedge clk) begin
      if (pre_we) begin
         mem_a[pre_addr] <= pre_dat;
         mem_d[pre_addr] <= pre_dat;
      end else if (ifa.O_mem_wren) begin
         mem_a[ifa.O_mem_addr] <= ifa.O_mem_data;
      end
      ifa.I_mem_data <= ifa.O_mem_rden ? mem_a[ifa.O_mem_addr] : 8'hEE;
      ifb.I_mem_data <= ifb.O_mem_rden ? ifb.O_mem_addr[7:0] : 8'hEE;
      ifc.I_mem_data <= ifc.O_mem_rden ? ifc.O_mem_addr[7:0] : 8'hEE;
      d_p1           <= ifd.O_mem_rden ? mem_d[ifd.O_mem_addr] : 8'hEE;
      d_p2           <= d_p1;
      ifd.I_mem_data <= d_p2;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int oh2i(input logic [7:0] v);
      int r;
      r = -1;
      for (int i = 0; i < 8; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Continuous invariants: at most one ack bit, never both strobes.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("a_ack_onehot", 32'($onehot0(ifa.O_ack)), 1);
         chk("b_ack_onehot", 32'($onehot0(ifb.O_ack)), 1);
         chk("c_ack_onehot", 32'($onehot0(ifc.O_ack)), 1);
         chk("d_ack_onehot", 32'($onehot0(ifd.O_ack)), 1);
         chk("a_strobe_excl", 32'(ifa.O_mem_rden & ifa.O_mem_wren), 0);
         chk("b_strobe_excl", 32'(ifb.O_mem_rden & ifb.O_mem_wren), 0);
         chk("d_strobe_excl", 32'(ifd.O_mem_rden & ifd.O_mem_wren), 0);
      end
   end

   typedef struct {
      int          ch;
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wd;
      logic [1:0]  exp_ack;
      logic        exp_rd_strobe;
      logic [7:0]  exp_rd0;
      logic [7:0]  exp_rd1;
   } vec_t;

   // One transaction on dut_a; entered and left just after a falling edge.
   task automatic run_vec_a(input vec_t v, input int k);
      int         lat, strobes, first;
      logic       rd_seen;
      logic [1:0] ackv;
      logic [7:0] r0, r1;
      lat = -1; strobes = 0; first = -1; rd_seen = 1'b0; ackv = '0; r0 = '0; r1 = '0;
      ifa.I_req[v.ch]              = 1'b1;
      ifa.I_we[v.ch]               = v.we;
      ifa.I_addr[v.ch*16 +: 16]    = v.addr;
      ifa.I_wdata[v.ch*8 +: 8]     = v.wd;
      for (int n = 1; n <= 10 && lat < 0; n++) begin
         @(negedge clk);
         if (ifa.O_mem_rden || ifa.O_mem_wren) begin
            strobes++;
            if (first < 0) first = n;
            if (ifa.O_mem_rden) rd_seen = 1'b1;
         end
         if (ifa.O_ack != '0) begin
            lat = n; ackv = ifa.O_ack; r0 = ifa.O_rdata[7:0]; r1 = ifa.O_rdata[15:8];
         end
      end
      ifa.I_req[v.ch] = 1'b0;
      chk($sformatf("vec%0d_ack", k), 32'(ackv), 32'(v.exp_ack));
      chk($sformatf("vec%0d_latency", k), lat, 3);
      chk($sformatf("vec%0d_strobe_cycles", k), strobes, 1);
      chk($sformatf("vec%0d_strobe_at", k), first, 1);
      chk($sformatf("vec%0d_strobe_kind", k), 32'(rd_seen), 32'(v.exp_rd_strobe));
      chk($sformatf("vec%0d_rdata0", k), 32'(r0), 32'(v.exp_rd0));
      chk($sformatf("vec%0d_rdata1", k), 32'(r1), 32'(v.exp_rd1));
      @(negedge clk);
   endtask

   vec_t vecs[6];
   int   exp_b[6]    = '{0, 1, 2, 3, 0, 1};
   int   exp_c[8]    = '{0, 1, 0, 2, 0, 1, 0, 2};
   int   exp_busy[6] = '{1, 1, 1, 1, 0, 0};
   int   exp_rden[6] = '{1, 0, 0, 0, 0, 0};
   int   exp_ackd[6] = '{0, 0, 0, 0, 1, 0};
   int   got, idx, last_cyc, lat;

   initial begin
      vecs[0] = '{1, 1'b0, 16'h4800, 8'h00, 2'b10, 1'b1, 8'h00, 8'h5A};
      vecs[1] = '{0, 1'b1, 16'h4000, 8'hC3, 2'b01, 1'b0, 8'h00, 8'h5A};
      vecs[2] = '{0, 1'b0, 16'h4000, 8'h00, 2'b01, 1'b1, 8'hC3, 8'h5A};
      vecs[3] = '{1, 1'b1, 16'h1234, 8'h77, 2'b10, 1'b0, 8'hC3, 8'h5A};
      vecs[4] = '{1, 1'b0, 16'h1234, 8'h00, 2'b10, 1'b1, 8'hC3, 8'h77};
      vecs[5] = '{0, 1'b0, 16'h4800, 8'h00, 2'b01, 1'b1, 8'h5A, 8'h77};

      ifa.I_req = '0; ifa.I_we = '0; ifa.I_addr = '0; ifa.I_wdata = '0;
      ifb.I_req = '0; ifb.I_we = '0; ifb.I_addr = '0; ifb.I_wdata = '0;
      ifc.I_req = '0; ifc.I_we = '0; ifc.I_addr = '0; ifc.I_wdata = '0;
      ifd.I_req = '0; ifd.I_we = '0; ifd.I_addr = '0; ifd.I_wdata = '0;

      // Reset state
      #2;
      chk("rst_a_ack",   32'(ifa.O_ack), 0);
      chk("rst_a_rdata", 32'(ifa.O_rdata), 0);
      chk("rst_a_addr",  32'(ifa.O_mem_addr), 0);
      chk("rst_a_rden",  32'(ifa.O_mem_rden), 0);
      chk("rst_a_wren",  32'(ifa.O_mem_wren), 0);
      chk("rst_a_wdata", 32'(ifa.O_mem_data), 0);
      chk("rst_a_busy",  32'(ifa.O_busy), 0);

      // Preload memories while the arbiters are held in reset.
      @(negedge clk); pre_we = 1'b1; pre_addr = 16'h4800; pre_dat = 8'h5A;
      @(negedge clk); pre_addr = 16'h0010; pre_dat = 8'hA7;
      @(negedge clk); pre_addr = 16'h0020; pre_dat = 8'h3C;
      @(negedge clk); pre_we = 1'b0; rst_n = 1'b1;
      @(negedge clk);

      // Read/write table on dut_a
      for (int k = 0; k < 6; k++) run_vec_a(vecs[k], k);

      // Request dropped and address changed after grant: original access completes.
      ifa.I_req[1] = 1'b1; ifa.I_we[1] = 1'b0; ifa.I_addr[31:16] = 16'h4800;
      @(negedge clk);
      ifa.I_req[1] = 1'b0; ifa.I_addr[31:16] = 16'h4000;
      lat = -1;
      for (int n = 2; n <= 10 && lat < 0; n++) begin
         @(negedge clk);
         if (ifa.O_ack != '0) begin
            lat = n;
            chk("viol_ack", 32'(ifa.O_ack), 32'h2);
            chk("viol_rdata1", 32'(ifa.O_rdata[15:8]), 32'h5A);
         end
      end
      chk("viol_latency", lat, 3);
      @(negedge clk);

      // dut_b: four requesters held, round-robin order and spacing
      ifb.I_req = 4'hF; ifb.I_we = 4'h0;
      for (int c = 0; c < 4; c++) ifb.I_addr[c*16 +: 16] = 16'h2020 + 16'(c);
      got = 0; last_cyc = -1;
      for (int n = 1; n <= 40 && got < 6; n++) begin
         @(negedge clk);
         if (ifb.O_ack != '0) begin
            idx = oh2i(8'(ifb.O_ack));
            chk($sformatf("b_order%0d", got), idx, exp_b[got]);
            chk($sformatf("b_cycle%0d", got), n, 3 + 4*got);
            if (idx >= 0) chk($sformatf("b_rdata%0d", got), 32'(ifb.O_rdata[idx*8 +: 8]), 32'h20 + 32'(exp_b[got]));
            got++;
            last_cyc = n;
         end
      end
      chk("b_ack_count", got, 6);
      ifb.I_req = '0;
      @(negedge clk); @(negedge clk);

      // dut_c: channel-0 priority, ch0 requests every other slot
      ifc.I_req = 3'b111; ifc.I_we = '0;
      got = 0;
      for (int n = 1; n <= 60 && got < 8; n++) begin
         @(negedge clk);
         if (ifc.O_ack != '0) begin
            idx = oh2i(8'(ifc.O_ack));
            chk($sformatf("c_order%0d", got), idx, exp_c[got]);
            ifc.I_req[0] = (idx != 0);
            got++;
         end
      end
      chk("c_ack_count", got, 8);
      ifc.I_req = '0;
      @(negedge clk); @(negedge clk);

      // dut_d: latency-3 read timing
      chk("d_busy_c0", 32'(ifd.O_busy), 0);
      ifd.I_req[0] = 1'b1; ifd.I_we[0] = 1'b0; ifd.I_addr[15:0] = 16'h0010;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         chk($sformatf("d_busy_c%0d", n), 32'(ifd.O_busy), exp_busy[n-1]);
         chk($sformatf("d_rden_c%0d", n), 32'(ifd.O_mem_rden), exp_rden[n-1]);
         chk($sformatf("d_ack0_c%0d", n), 32'(ifd.O_ack[0]), exp_ackd[n-1]);
         if (n == 5) begin
            chk("d_rdata0", 32'(ifd.O_rdata[7:0]), 32'hA7);
            ifd.I_req[0] = 1'b0;
         end
      end

      // dut_d: asynchronous reset while waiting on a read
      ifd.I_req[0] = 1'b1; ifd.I_addr[15:0] = 16'h0010;
      @(negedge clk);
      @(negedge clk);
      chk("d_wait_busy", 32'(ifd.O_busy), 1);
      rst_n = 1'b0;
      ifd.I_req = '0;
      #1;
      chk("d_rst_ack",   32'(ifd.O_ack), 0);
      chk("d_rst_rdata", 32'(ifd.O_rdata), 0);
      chk("d_rst_addr",  32'(ifd.O_mem_addr), 0);
      chk("d_rst_rden",  32'(ifd.O_mem_rden), 0);
      chk("d_rst_wren",  32'(ifd.O_mem_wren), 0);
      chk("d_rst_wdata", 32'(ifd.O_mem_data), 0);
      chk("d_rst_busy",  32'(ifd.O_busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         chk($sformatf("d_no_stale_ack%0d", n), 32'(ifd.O_ack), 0);
      end

      // Both channels request after reset: pointer restart means ch0 first.
      ifd.I_req = 2'b11; ifd.I_we = 2'b00;
      ifd.I_addr = {16'h0020, 16'h0010};
      got = 0;
      for (int n = 1; n <= 20 && got < 2; n++) begin
         @(negedge clk);
         if (ifd.O_ack != '0) begin
            if (got == 0) begin
               chk("d_post_first_ack", 32'(ifd.O_ack), 32'h1);
               chk("d_post_first_cyc", n, 5);
               chk("d_post_rdata0", 32'(ifd.O_rdata[7:0]), 32'hA7);
               ifd.I_req[0] = 1'b0;
            end else begin
               chk("d_post_second_ack", 32'(ifd.O_ack), 32'h2);
               chk("d_post_second_cyc", n, 11);
               chk("d_post_rdata1", 32'(ifd.O_rdata[15:8]), 32'h3C);
               ifd.I_req[1] = 1'b0;
            end
            got++;
         end
      end
      chk("d_post_ack_count", got, 2);
      @(negedge clk); @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end
endmodule
